// File: rtl/sha256_pkg.sv
// Shared constants, FSM state type and bitwise helper functions for the
// single-block SHA-256 hasher.
package sha256_pkg;

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_e;

    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [0:7][31:0] H_INIT = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_pad.sv
// Combinational padder: {message, 1, zeros, 64-bit length} into one block.
module sha256_pad
    import sha256_pkg::*;
#(
    parameter int MSG_SIZE    = 96,
    parameter int PADDED_SIZE = 512
) (
    input  logic [MSG_SIZE-1:0]    message,
    output logic [PADDED_SIZE-1:0] block
);

    // Built by field writes so MSG_SIZE = 447 (no zero fill) needs no special case.
    always_comb begin
        block = '0;
        block[PADDED_SIZE-1 -: MSG_SIZE]  = message;
        block[PADDED_SIZE-1-MSG_SIZE]     = 1'b1;
        block[63:0]                       = 64'(MSG_SIZE);
    end

endmodule

// File: rtl/sha256_top.sv
// Single-block SHA-256: pads the message, runs 64 rounds one per clock and
// holds the digest in a register that changes only in FINAL.
module sha256_top
    import sha256_pkg::*;
#(
    parameter int MSG_SIZE    = 96,
    parameter int PADDED_SIZE = 512
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [MSG_SIZE-1:0] message,
    input  logic                en,
    output logic [255:0]        hashed
);

    generate
        if (PADDED_SIZE != 512) begin : g_bad_padded
            $error("sha256_top: PADDED_SIZE must be 512");
        end
        if (MSG_SIZE < 1 || MSG_SIZE > PADDED_SIZE - 65) begin : g_bad_msg
            $error("sha256_top: MSG_SIZE must be 1..PADDED_SIZE-65");
        end
    endgenerate

    logic [511:0]       block;
    state_e             state_q, state_d;
    logic [5:0]         t_q, t_d;
    logic [0:7][31:0]   work_q, work_d;   // a..h
    logic [0:15][31:0]  win_q, win_d;     // win_q[0] is W[t]
    logic [255:0]       hashed_q, hashed_d;
    logic [31:0]        t1, t2, w_new;

    sha256_pad #(.MSG_SIZE(MSG_SIZE), .PADDED_SIZE(512)) u_pad (
        .message (message),
        .block   (block)
    );

    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        work_d   = work_q;
        win_d    = win_q;
        hashed_d = hashed_q;

        t1 = work_q[7] + big_sigma1(work_q[4]) + ch(work_q[4], work_q[5], work_q[6])
           + K[t_q] + win_q[0];
        t2 = big_sigma0(work_q[0]) + maj(work_q[0], work_q[1], work_q[2]);
        // W[t+16] from the window: W[t+14], W[t+9], W[t+1], W[t]
        w_new = small_sigma1(win_q[14]) + win_q[9] + small_sigma0(win_q[1]) + win_q[0];

        case (state_q)
            IDLE: begin
                if (en) begin
                    win_d   = block;
                    work_d  = H_INIT;
                    t_d     = '0;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                work_d = {t1 + t2, work_q[0], work_q[1], work_q[2],
                          work_q[3] + t1, work_q[4], work_q[5], work_q[6]};
                win_d  = {win_q[1:15], w_new};
                t_d    = t_q + 6'd1;
                if (t_q == 6'd63) state_d = FINAL;
            end
            FINAL: begin
                hashed_d = {H_INIT[0] + work_q[0], H_INIT[1] + work_q[1],
                            H_INIT[2] + work_q[2], H_INIT[3] + work_q[3],
                            H_INIT[4] + work_q[4], H_INIT[5] + work_q[5],
                            H_INIT[6] + work_q[6], H_INIT[7] + work_q[7]};
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            t_q      <= '0;
            work_q   <= '0;
            win_q    <= '0;
            hashed_q <= '0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            work_q   <= work_d;
            win_q    <= win_d;
            hashed_q <= hashed_d;
        end
    end

    assign hashed = hashed_q;

endmodule

// File: tb/tb_sha256_top.sv
// Directed bench: "abc" at MSG_SIZE=24 and "hello world!" at MSG_SIZE=96,
// covering reset hold, exact latency, back-to-back period, mid-run changes and reset.
module tb_sha256_top;

    localparam logic [255:0] D_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_HW =
        256'h7509e5bda0c762d2bac7f90d758b5b2263fa01ccbc542ab5e3df163be08e6ca9;
    localparam logic [23:0] M_ABC = 24'h616263;
    localparam logic [95:0] M_HW  = 96'h68656c6c6f20776f726c6421;

    logic         clk = 1'b0;
    logic         reset;
    logic         en_abc, en_hw;
    logic [23:0]  msg_abc;
    logic [95:0]  msg_hw;
    logic [255:0] hashed_abc, hashed_hw;
    int           checks   = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    sha256_top #(.MSG_SIZE(24), .PADDED_SIZE(512)) u_abc (
        .clk     (clk),
        .reset   (reset),
        .message (msg_abc),
        .en      (en_abc),
        .hashed  (hashed_abc)
    );

    sha256_top #(.MSG_SIZE(96), .PADDED_SIZE(512)) u_hw (
        .clk     (clk),
        .reset   (reset),
        .message (msg_hw),
        .en      (en_hw),
        .hashed  (hashed_hw)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // n rising edges, then settle on the following falling edge
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset   = 1'b0;
        en_abc  = 1'b1;
        en_hw   = 1'b1;
        msg_abc = M_ABC;
        msg_hw  = M_HW;

        // reset held with en high: digest stays zero
        @(negedge clk);
        chk("rst_abc_0", hashed_abc, '0);
        chk("rst_hw_0", hashed_hw, '0);
        cycles(50);
        chk("rst_abc_50", hashed_abc, '0);
        cycles(50);
        chk("rst_abc_100", hashed_abc, '0);
        chk("rst_hw_100", hashed_hw, '0);
        en_abc = 1'b0;
        en_hw  = 1'b0;
        reset  = 1'b1;
        cycles(3);
        chk("idle_no_en", hashed_abc, '0);

        // "abc": one-cycle pulse, exact latency
        en_abc = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en_abc = 1'b0;
        cycles(64);
        chk("abc_e64", hashed_abc, '0);
        cycles(1);
        chk("abc_e65", hashed_abc, D_ABC);
        cycles(10);
        chk("abc_hold", hashed_abc, D_ABC);

        // "hello world!" at the default width
        en_hw = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en_hw = 1'b0;
        cycles(64);
        chk("hw_e64", hashed_hw, '0);
        cycles(1);
        chk("hw_e65", hashed_hw, D_HW);
        cycles(2);

        // clear both digests
        reset = 1'b0;
        #1;
        chk("clr_abc", hashed_abc, '0);
        chk("clr_hw", hashed_hw, '0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // en held: second capture must land exactly on E+66, the only
        // edge at which the good message is present
        en_hw  = 1'b1;
        msg_hw = M_HW;
        @(posedge clk);
        @(negedge clk);
        msg_hw = 96'hdeadbeef_cafef00d_01234567;
        cycles(64);
        chk("cont_e64", hashed_hw, '0);
        cycles(1);
        chk("cont_e65", hashed_hw, D_HW);
        msg_hw = M_HW;
        cycles(1);
        msg_hw = 96'hdeadbeef_cafef00d_01234567;
        en_hw  = 1'b0;
        cycles(64);
        chk("cont_e130_hold", hashed_hw, D_HW);
        cycles(1);
        chk("cont_e131", hashed_hw, D_HW);
        cycles(2);

        // message and en changed at round 10: captured message wins
        msg_abc = M_ABC;
        en_abc  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cycles(10);
        msg_abc = 24'hffffff;
        en_abc  = 1'b0;
        cycles(54);
        chk("midchg_e64", hashed_abc, '0);
        cycles(1);
        chk("midchg_e65", hashed_abc, D_ABC);
        cycles(2);

        // reset at round 30 aborts and clears at once
        msg_hw = M_HW;
        en_hw  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en_hw = 1'b0;
        cycles(30);
        chk("pre_midrst", hashed_hw, D_HW);
        reset = 1'b0;
        #1;
        chk("midrst_hw", hashed_hw, '0);
        chk("midrst_abc", hashed_abc, '0);
        en_hw = 1'b1;
        cycles(3);
        chk("midrst_hold", hashed_hw, '0);
        en_hw = 1'b0;
        reset = 1'b1;
        cycles(70);
        chk("postrst_idle", hashed_hw, '0);
        en_hw = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en_hw = 1'b0;
        cycles(64);
        chk("postrst_e64", hashed_hw, '0);
        cycles(1);
        chk("postrst_e65", hashed_hw, D_HW);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
